// File: rtl/rwave_peak_scan_pkg.sv
// Shared definitions for the R-wave peak scanner: FSM encodings and size defaults.
// The upstream sample memory is built with the same DEPTH.
package rwave_peak_scan_pkg;

  localparam int unsigned DATA_W_DEF = 16;   // signed sample width
  localparam int unsigned IDX_W_DEF  = 10;   // index / window length width
  localparam int unsigned DEPTH_DEF  = 800;  // FIFO depth, upper clamp for the window

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rwave_peak_scan_if.sv
// Control, FIFO-tap and result signals of the peak scanner.
//   master : controller/FIFO side (drives Enable, start, modes, win_len, r_thresh, tap1/tap2)
//   slave  : the scanner (drives stop1/stop2, busy, done and the result fields)
interface rwave_peak_scan_if
  import rwave_peak_scan_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
);
  logic                     Enable;
  logic                     start;
  logic                     serial_mode;
  logic                     parallel_mode;
  logic [IDX_W-1:0]         win_len;
  logic signed [DATA_W-1:0] r_thresh;
  logic signed [DATA_W-1:0] tap1;
  logic signed [DATA_W-1:0] tap2;
  logic                     stop1;
  logic                     stop2;
  logic                     busy;
  logic                     done;
  logic                     r_valid;
  logic signed [DATA_W-1:0] r_amp;
  logic [IDX_W-1:0]         r_idx;
  logic signed [DATA_W-1:0] s_amp;
  logic [IDX_W-1:0]         s_idx;

  modport master (
    output Enable, start, serial_mode, parallel_mode, win_len, r_thresh, tap1, tap2,
    input  stop1, stop2, busy, done, r_valid, r_amp, r_idx, s_amp, s_idx
  );

  modport slave (
    input  Enable, start, serial_mode, parallel_mode, win_len, r_thresh, tap1, tap2,
    output stop1, stop2, busy, done, r_valid, r_amp, r_idx, s_amp, s_idx
  );
endinterface

// File: rtl/rwave_peak_scan_extremum_tracker.sv
// Running extremum (max when FIND_MAX, else min) of a signed sample stream with its index.
// Ports: clk, Reset (async, active-high); load forces the current sample in, update allows a
// strict improvement; best_c/best_idx_c are the values including the current sample, so the
// caller can capture the final result on the same edge as the last sample.
module rwave_peak_scan_extremum_tracker
  import rwave_peak_scan_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter bit          FIND_MAX = 1'b1
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     load,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] sample,
  input  logic [IDX_W-1:0]         idx,
  output logic signed [DATA_W-1:0] best_c,
  output logic [IDX_W-1:0]         best_idx_c
);

  logic signed [DATA_W-1:0] best_q;
  logic [IDX_W-1:0]         best_idx_q;
  logic                     better;

  // Strict compare: ties keep the earliest index.
  always_comb begin
    better     = FIND_MAX ? (sample > best_q) : (sample < best_q);
    best_c     = best_q;
    best_idx_c = best_idx_q;
    if (load || (update && better)) begin
      best_c     = sample;
      best_idx_c = idx;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      best_q     <= best_c;
      best_idx_q <= best_idx_c;
    end
  end

endmodule

// File: rtl/rwave_peak_scan.sv
// R-wave peak scanner. Shifts FIFO A (and B in parallel mode) once per cycle over a window and
// reports the max of tap1 (R-peak) and the min of tap2 (S-trough) with first-occurrence indices.
// Ports: clk, Reset (async, active-high), bus (slave modport of rwave_peak_scan_if).
module rwave_peak_scan
  import rwave_peak_scan_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  rwave_peak_scan_if.slave bus
);

  state_e                   state;
  logic [IDX_W-1:0]         len_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] thresh_q;
  logic                     par_q;
  logic                     stop1_q, stop2_q, busy_q, done_q, r_valid_q;
  logic signed [DATA_W-1:0] r_amp_q, s_amp_q;
  logic [IDX_W-1:0]         r_idx_q, s_idx_q;

  logic [IDX_W-1:0]         len_clamped;
  logic                     in_scan, first, last, go, par_sel;
  logic signed [DATA_W-1:0] max_val, min_val;
  logic [IDX_W-1:0]         max_idx, min_idx;

  // Window length clamped to 1..DEPTH.
  always_comb begin
    len_clamped = bus.win_len;
    if (bus.win_len == '0) begin
      len_clamped = IDX_W'(1);
    end else if (bus.win_len > IDX_W'(DEPTH)) begin
      len_clamped = IDX_W'(DEPTH);
    end
  end

  assign in_scan = (state == ST_SCAN);
  assign first   = in_scan && (idx_q == '0);
  assign last    = (idx_q == len_q - IDX_W'(1));
  assign go      = bus.start && bus.Enable && (bus.serial_mode || bus.parallel_mode);
  assign par_sel = bus.parallel_mode && !bus.serial_mode;

  rwave_peak_scan_extremum_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W), .FIND_MAX(1'b1)) u_max (
    .clk        (clk),
    .Reset      (Reset),
    .load       (first),
    .update     (in_scan),
    .sample     (bus.tap1),
    .idx        (idx_q),
    .best_c     (max_val),
    .best_idx_c (max_idx)
  );

  rwave_peak_scan_extremum_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W), .FIND_MAX(1'b0)) u_min (
    .clk        (clk),
    .Reset      (Reset),
    .load       (first && par_q),
    .update     (in_scan && par_q),
    .sample     (bus.tap2),
    .idx        (idx_q),
    .best_c     (min_val),
    .best_idx_c (min_idx)
  );

  // FSM, index counter, latches and result registers. Results are captured on the
  // last-sample edge so they appear together with the done pulse.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      thresh_q  <= '0;
      par_q     <= 1'b0;
      stop1_q   <= 1'b0;
      stop2_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_amp_q   <= '0;
      r_idx_q   <= '0;
      s_amp_q   <= '0;
      s_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_SCAN;
            len_q    <= len_clamped;
            thresh_q <= bus.r_thresh;
            par_q    <= par_sel;
            idx_q    <= '0;
            stop1_q  <= 1'b1;
            stop2_q  <= par_sel;
            busy_q   <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!bus.Enable) begin
            state   <= ST_IDLE;
            stop1_q <= 1'b0;
            stop2_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (last) begin
            state     <= ST_DONE;
            stop1_q   <= 1'b0;
            stop2_q   <= 1'b0;
            done_q    <= 1'b1;
            r_amp_q   <= max_val;
            r_idx_q   <= max_idx;
            r_valid_q <= (max_val >= thresh_q);
            if (par_q) begin
              s_amp_q <= min_val;
              s_idx_q <= min_idx;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          stop1_q <= 1'b0;
          stop2_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stop1   = stop1_q;
  assign bus.stop2   = stop2_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.r_valid = r_valid_q;
  assign bus.r_amp   = r_amp_q;
  assign bus.r_idx   = r_idx_q;
  assign bus.s_amp   = s_amp_q;
  assign bus.s_idx   = s_idx_q;

endmodule
